// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: memory freeze, branch and interrupt redirects,
// load-use bubbles, memory-timeout flag and a stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] IRQ_VEC = 32'h0000_0100,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic        EX_mem_read,
  input  logic [4:0]  EX_rd,
  input  logic        EX_branch_taken,
  input  logic [31:0] EX_target,
  input  logic        MEM_req,
  input  logic        MEM_ready,
  input  logic        irq,
  output logic        pc_stall,
  output logic        IF_flush,
  output logic [31:0] jmp_data,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_stall,
  output logic        ID_EX_flush,
  output logic        EX_MEM_stall,
  output logic        MEM_WB_flush,
  output logic        irq_ack,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_ERR = WCW'(TIMEOUT - 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic           irq_pending_q, irq_pending_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_err_q, mem_err_d;
  logic [31:0]    stall_cnt_q, stall_cnt_d;

  logic freeze, load_use, irq_take;

  always_comb begin
    freeze   = MEM_req & ~MEM_ready;
    load_use = EX_mem_read & (EX_rd != 5'd0) &
               ((ID_use_rs1 & (ID_rs1 == EX_rd)) | (ID_use_rs2 & (ID_rs2 == EX_rd)));
    irq_take = irq_pending_q & ~freeze & ~EX_branch_taken;
  end

  // Priority chain: freeze > branch > pending irq > load-use.
  always_comb begin
    pc_stall     = 1'b0;
    IF_flush     = 1'b0;
    jmp_data     = '0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    irq_ack      = 1'b0;
    if (freeze) begin
      pc_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_EX_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
      MEM_WB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      IF_flush    = 1'b1;
      jmp_data    = EX_target;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (irq_pending_q) begin
      IF_flush    = 1'b1;
      jmp_data    = IRQ_VEC;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      irq_ack     = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze)  state_d = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase

    irq_pending_d = irq | (irq_pending_q & ~irq_take);

    if (freeze) wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
    else        wait_cnt_d = '0;

    // wait_cnt_q holds the freeze cycles already completed, so TIMEOUT-1 marks the last one.
    mem_err_d   = mem_err_q | (freeze & (wait_cnt_q >= WAIT_ERR));
    stall_cnt_d = pc_stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      irq_pending_q <= 1'b0;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      irq_pending_q <= irq_pending_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: fixed vector table, directed corner sequences
// and randomized traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam logic [31:0] IRQ_VEC = 32'h0000_0100;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2, EX_mem_read, EX_branch_taken;
  logic [31:0] EX_target;
  logic        MEM_req, MEM_ready, irq;
  logic        pc_stall, IF_flush, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
  logic        EX_MEM_stall, MEM_WB_flush, irq_ack, mem_err;
  logic [31:0] jmp_data, stall_cnt;

  pipe_ctrl #(.IRQ_VEC(IRQ_VEC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_mem_read(EX_mem_read), .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken),
    .EX_target(EX_target), .MEM_req(MEM_req), .MEM_ready(MEM_ready), .irq(irq),
    .pc_stall(pc_stall), .IF_flush(IF_flush), .jmp_data(jmp_data),
    .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_stall(ID_EX_stall),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall), .MEM_WB_flush(MEM_WB_flush),
    .irq_ack(irq_ack), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: pending interrupt, length of current freeze run, error, stall count.
  bit          m_pend;
  int          m_run;
  bit          m_err;
  logic [31:0] m_stall;
  logic [8:0]  e_ctl;
  logic [31:0] e_jmp;

  // Control bit order: pc_stall IF_flush IF_ID_stall IF_ID_flush ID_EX_stall ID_EX_flush EX_MEM_stall MEM_WB_flush irq_ack
  localparam logic [8:0] C_NONE   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] C_LU     = 9'b1_0_1_0_0_1_0_0_0;
  localparam logic [8:0] C_REDIR  = 9'b0_1_0_1_0_1_0_0_0;
  localparam logic [8:0] C_IRQ    = 9'b0_1_0_1_0_1_0_0_1;
  localparam logic [8:0] C_FREEZE = 9'b1_0_1_0_1_0_1_1_0;

  function automatic logic [8:0] act_ctl();
    return {pc_stall, IF_flush, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
            EX_MEM_stall, MEM_WB_flush, irq_ack};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    bit fz, lu;
    fz = MEM_req && !MEM_ready;
    lu = EX_mem_read && EX_rd != 0 &&
         ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
    e_jmp = 32'd0;
    if (fz)                   e_ctl = C_FREEZE;
    else if (EX_branch_taken) begin e_ctl = C_REDIR; e_jmp = EX_target; end
    else if (m_pend)          begin e_ctl = C_IRQ;   e_jmp = IRQ_VEC;   end
    else if (lu)              e_ctl = C_LU;
    else                      e_ctl = C_NONE;
  endtask

  task automatic model_edge();
    bit fz, taken;
    fz = MEM_req && !MEM_ready;
    taken = e_ctl[0];
    m_pend = irq || (m_pend && !taken);
    m_run = fz ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_err = 1'b1;
    if (e_ctl[8]) m_stall = m_stall + 32'd1;
  endtask

  task automatic idle_inputs();
    ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0; EX_mem_read = 0; EX_rd = 0;
    EX_branch_taken = 0; EX_target = 0; MEM_req = 0; MEM_ready = 0; irq = 0;
  endtask

  // Inputs are set at the falling edge before calling; checks land 1ns later.
  task automatic cycle();
    #1;
    model_comb();
    chk("ctl", {23'd0, act_ctl()}, {23'd0, e_ctl});
    chk("jmp_data", jmp_data, e_jmp);
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    chk("stall_cnt", stall_cnt, m_stall);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_ctl", {23'd0, act_ctl()}, 32'd0);
    chk("rst_jmp", jmp_data, 32'd0);
    chk("rst_err_cnt", {mem_err, stall_cnt[30:0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pend = 0; m_run = 0; m_err = 0; m_stall = 0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    EX_mem_read = 1; EX_rd = r; ID_rs1 = r; ID_use_rs1 = 1;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, mr;
    logic [4:0]  rd;
    logic        br;
    logic [31:0] tgt;
    logic        mreq, mrdy;
    logic [8:0]  ctl;
    logic [31:0] jmp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,     0, 0, C_NONE,   0};
    vecs[1]  = '{5, 0, 1, 0, 1, 5, 0, 0,     0, 0, C_LU,     0};
    vecs[2]  = '{1, 7, 0, 1, 1, 7, 0, 0,     0, 0, C_LU,     0};
    vecs[3]  = '{0, 0, 1, 1, 1, 0, 0, 0,     0, 0, C_NONE,   0};
    vecs[4]  = '{5, 0, 0, 0, 1, 5, 0, 0,     0, 0, C_NONE,   0};
    vecs[5]  = '{5, 0, 1, 0, 0, 5, 0, 0,     0, 0, C_NONE,   0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, C_REDIR, 32'h40};
    vecs[7]  = '{5, 0, 1, 0, 1, 5, 1, 32'h40, 0, 0, C_REDIR, 32'h40};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,     1, 0, C_FREEZE, 0};
    vecs[9]  = '{5, 0, 1, 0, 1, 5, 1, 32'h80, 1, 0, C_FREEZE, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0,     1, 1, C_NONE,   0};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Table of single-cycle actions from idle state.
    for (int i = 0; i < 11; i++) begin
      ID_rs1 = vecs[i].rs1; ID_rs2 = vecs[i].rs2; ID_use_rs1 = vecs[i].u1;
      ID_use_rs2 = vecs[i].u2; EX_mem_read = vecs[i].mr; EX_rd = vecs[i].rd;
      EX_branch_taken = vecs[i].br; EX_target = vecs[i].tgt;
      MEM_req = vecs[i].mreq; MEM_ready = vecs[i].mrdy; irq = 0;
      #1;
      chk($sformatf("vec%0d_ctl", i), {23'd0, act_ctl()}, {23'd0, vecs[i].ctl});
      chk($sformatf("vec%0d_jmp", i), jmp_data, vecs[i].jmp);
      #1;
      cycle();
    end

    // Load-use bubble counts once; branch beats load-use without counting.
    do_reset();
    set_lu(5'd5);
    cycle();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    EX_branch_taken = 1; EX_target = 32'h40;
    cycle();
    chk("br_lu_stall_cnt", stall_cnt, 32'd1);

    // Short freeze, then a TIMEOUT-long freeze setting a sticky error.
    do_reset();
    MEM_req = 1; MEM_ready = 0;
    repeat (3) cycle();
    MEM_ready = 1;
    cycle();
    chk("frz3_stall_cnt", stall_cnt, 32'd3);
    chk("frz3_mem_err", {31'd0, mem_err}, 32'd0);
    do_reset();
    MEM_req = 1; MEM_ready = 0;
    repeat (TIMEOUT - 1) cycle();
    chk("frz15_mem_err", {31'd0, mem_err}, 32'd0);
    cycle();
    chk("frz16_mem_err", {31'd0, mem_err}, 32'd1);
    repeat (3) cycle();
    MEM_req = 0;
    repeat (2) cycle();
    chk("err_sticky", {31'd0, mem_err}, 32'd1);
    chk("frz_stall_cnt", stall_cnt, 32'(TIMEOUT + 3));

    // Interrupt arriving during a freeze is taken in the first unfrozen cycle.
    do_reset();
    MEM_req = 1; MEM_ready = 0; irq = 1;
    cycle();
    irq = 0;
    repeat (2) cycle();
    MEM_ready = 1;
    #1;
    chk("irq_after_frz_ack", {31'd0, irq_ack}, 32'd1);
    chk("irq_after_frz_jmp", jmp_data, IRQ_VEC);
    cycle();
    chk("irq_single_ack", {31'd0, irq_ack}, 32'd0);
    cycle();

    // Same, but the unfrozen cycle carries a branch: branch first, ack next cycle.
    do_reset();
    MEM_req = 1; MEM_ready = 0; irq = 1;
    cycle();
    irq = 0; MEM_ready = 1; EX_branch_taken = 1; EX_target = 32'h200;
    #1;
    chk("irq_br_ack0", {31'd0, irq_ack}, 32'd0);
    chk("irq_br_jmp", jmp_data, 32'h200);
    cycle();
    EX_branch_taken = 0;
    #1;
    chk("irq_br_ack1", {31'd0, irq_ack}, 32'd1);
    cycle();

    // Asynchronous reset mid-freeze with an interrupt pending and counters non-zero.
    MEM_req = 1; MEM_ready = 0; irq = 1;
    repeat (TIMEOUT + 1) cycle();
    irq = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_stall_cnt", stall_cnt, 32'd0);
    chk("async_mem_err", {31'd0, mem_err}, 32'd0);
    idle_inputs();
    #1;
    chk("async_ctl", {23'd0, act_ctl()}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pend = 0; m_run = 0; m_err = 0; m_stall = 0;
    cycle();
    chk("async_irq_cleared", {31'd0, irq_ack}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
      ID_use_rs1 = 1'($urandom); ID_use_rs2 = 1'($urandom);
      EX_mem_read = 1'($urandom); EX_rd = 5'($urandom_range(0, 3));
      EX_branch_taken = ($urandom_range(0, 6) == 0);
      EX_target = $urandom;
      MEM_req = ($urandom_range(0, 2) == 0);
      MEM_ready = ($urandom_range(0, 3) == 0);
      irq = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter IRQ_VEC, default 32'h0000_0100, interrupt redirect target.
REQ-002 SHALL have parameter TIMEOUT, default 16, consecutive memory-wait cycles before mem_err.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ID_rs1, ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ID_use_rs1, ID_use_rs2  input  1 each  the ID instruction reads that source.
REQ-007 SHALL have EX_mem_read  input  1  the EX instruction is a load.
REQ-008 SHALL have EX_rd  input  5  destination register of the EX instruction.
REQ-009 SHALL have EX_branch_taken  input  1  the EX branch/jump resolved taken.
REQ-010 SHALL have EX_target  input  32  resolved redirect address.
REQ-011 SHALL have MEM_req, MEM_ready  input  1 each  MEM-stage data access pending / completes this cycle.
REQ-012 SHALL have irq  input  1  interrupt request pulse, any cycle, any width.
REQ-013 SHALL have pc_stall  output  1  hold PC register (drives the PC register's ID_stall).
REQ-014 SHALL have IF_flush  output  1  PC register loads jmp_data.
REQ-015 SHALL have jmp_data  output  32  redirect address.
REQ-016 SHALL have IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush  output  1 each  pipeline register hold / bubble controls.
REQ-017 SHALL have irq_ack  output  1  one-cycle pulse when an interrupt redirect is issued.
REQ-018 SHALL have mem_err  output  1  sticky memory-timeout flag.
REQ-019 SHALL have stall_cnt  output  32  count of cycles with pc_stall=1.

Function
REQ-020 freeze SHALL equal MEM_req & ~MEM_ready, combinational.
REQ-021 load_use SHALL equal EX_mem_read & (EX_rd!=0) & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
REQ-022 Each cycle exactly one action SHALL apply, priority: freeze > branch > irq > load_use > none.
REQ-023 freeze action: pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_flush =1; all other controls 0.
REQ-024 branch action (EX_branch_taken, no freeze): IF_flush=1, jmp_data=EX_target, IF_ID_flush=1, ID_EX_flush=1, pc_stall=0.
REQ-025 irq_pending register SHALL set at any edge where irq=1; irq action eligible only from registered irq_pending (1-cycle min latency).
REQ-026 irq action: IF_flush=1, jmp_data=IRQ_VEC, IF_ID_flush=1, ID_EX_flush=1, irq_ack=1; irq_pending clears at that edge unless irq=1 same cycle (set wins).
REQ-027 irq blocked by freeze or branch SHALL remain pending, no loss; repeated irq while pending SHALL merge into one.
REQ-028 load_use action: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1; exactly one bubble per hazard.
REQ-029 jmp_data SHALL be 0 whenever IF_flush=0; unlisted controls SHALL be 0.
REQ-030 FSM states RUN, MEM_WAIT: RUN->MEM_WAIT on freeze; MEM_WAIT->RUN when freeze=0; freeze outputs are combinational in both states.
REQ-031 wait_cnt SHALL increment each freeze cycle, saturate at TIMEOUT, clear on any non-freeze cycle.
REQ-032 mem_err SHALL set at the edge ending the TIMEOUT-th consecutive freeze cycle, stay set until reset; pipeline keeps freezing.
REQ-033 stall_cnt SHALL increment by 1 at each edge where pc_stall=1, wrapping 2^32-1 -> 0.

Reset
REQ-034 rst=1 SHALL immediately force state=RUN, irq_pending=0, wait_cnt=0, mem_err=0, stall_cnt=0, independent of clk.
REQ-035 With rst=1 and all inputs 0, every output SHALL be 0.

Verification
REQ-036 EX_mem_read=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> pc_stall=IF_ID_stall=ID_EX_flush=1, stall_cnt 0->1; EX_rd=0, ID_rs1=0 -> no stall.
REQ-037 load_use plus EX_branch_taken, EX_target=0x40 -> IF_flush=1, jmp_data=0x40, pc_stall=0, stall_cnt unchanged.
REQ-038 MEM_req=1, MEM_ready=0 for 3 cycles then MEM_ready=1 -> freeze controls 3 cycles, stall_cnt +3, mem_err=0; 16-cycle hold -> mem_err=1, persists after release.
REQ-039 irq pulse during freeze -> irq_ack, jmp_data=0x100 in first unfrozen cycle; if that cycle has branch, branch first, irq_ack next cycle.
REQ-040 rst asserted mid-freeze with irq pending -> state RUN, irq_pending=0, stall_cnt=0, mem_err=0 before next clk edge.
